// File: rtl/wb_init_pkg.sv
// Shared types and helpers for the Wishbone command initiator.
//   state_e  : initiator FSM states
//   status_e : response status codes as seen on o_rsp_status
//   sel_to_mask : expands 4 byte enables into a 32-bit data mask
package wb_init_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUS  = 2'b01,
    S_GAP  = 2'b10,
    S_RESP = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_ERR     = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_e;

  // Bit i of sel enables byte lane i (bits 8*i+7 .. 8*i).
  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_wait_timer.sv
// Saturating wait counter used to detect a bus slave that never answers.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear to zero (wins over en_i)
//   en_i       : count one wait cycle
//   expired_o  : high when the current enabled tick brings the count to LIMIT
// LIMIT = 0 disables expiry; the counter then still saturates and never wraps.
module wb_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int            CW   = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CW-1:0] SAT  = (LIMIT > 0) ? CW'(LIMIT) : {CW{1'b1}};
  localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : {CW{1'b0}};

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CW{1'b0}};
    end else if (en_i && (cnt_q != SAT)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The tick that moves the count from LIMIT-1 to LIMIT is the expiring one,
  // so a slave gets exactly LIMIT bus cycles.
  assign expired_o = (LIMIT > 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/wb_cmd_initiator.sv
// Wishbone-classic 32-bit bus master, one outstanding transfer.
// A command accepted on the cmd valid/ready port becomes one Wishbone cycle;
// the outcome is returned on the rsp valid/ready port.
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready, i_cmd_we/adr/sel/dat : command port
//   o_rsp_valid/i_rsp_ready, o_rsp_dat/status      : response port (00 OK, 01 ERR, 10 TIMEOUT)
//   o_wb_adr/sel/we/dat/cyc/stb, i_wb_dat/ack/err  : Wishbone master bus
// Slave errors are retried up to RETRY_MAX times with a one-cycle cyc-low gap;
// TIMEOUT_CYC bus cycles without ack/err abort the transfer (0 disables).
module wb_cmd_initiator
  import wb_init_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int RETRY_MAX   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_we,
  input  logic [31:0] i_cmd_adr,
  input  logic [3:0]  i_cmd_sel,
  input  logic [31:0] i_cmd_dat,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_dat,
  output logic [1:0]  o_rsp_status,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err
);

  localparam int            RW        = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

  state_e        state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  status_e       status_q, status_d;
  logic [31:0]   rsp_dat_q, rsp_dat_d;
  logic          we_q;
  logic [31:0]   adr_q, dat_q;
  logic [3:0]    sel_q;
  logic          rdy_q, cyc_q, rsp_valid_q;
  logic          cmd_take_s, tmr_clr_s, tmr_en_s, tmr_expired_s;

  wb_wait_timer #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmr_clr_s),
    .en_i     (tmr_en_s),
    .expired_o(tmr_expired_s)
  );

  // Next-state, retry/status/response-data decisions and timer control.
  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    status_d   = status_q;
    rsp_dat_d  = rsp_dat_q;
    cmd_take_s = 1'b0;
    tmr_clr_s  = 1'b0;
    tmr_en_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          cmd_take_s = 1'b1;
          tmr_clr_s  = 1'b1;
          retry_d    = {RW{1'b0}};
          state_d    = S_BUS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUS: begin
        // err outranks a simultaneous ack
        if (i_wb_err) begin
          if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + RW'(1);
            state_d = S_GAP;
          end else begin
            status_d  = ST_ERR;
            rsp_dat_d = 32'h0000_0000;
            state_d   = S_RESP;
          end
        end else if (i_wb_ack) begin
          status_d  = ST_OK;
          rsp_dat_d = we_q ? 32'h0000_0000 : (i_wb_dat & sel_to_mask(sel_q));
          state_d   = S_RESP;
        end else begin
          tmr_en_s = 1'b1;
          if (tmr_expired_s) begin
            status_d  = ST_TIMEOUT;
            rsp_dat_d = 32'h0000_0000;
            state_d   = S_RESP;
          end else begin
            state_d = S_BUS;
          end
        end
      end
      S_GAP: begin
        tmr_clr_s = 1'b1;
        state_d   = S_BUS;
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, retry count and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      retry_q   <= {RW{1'b0}};
      status_q  <= ST_OK;
      rsp_dat_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      status_q  <= status_d;
      rsp_dat_q <= rsp_dat_d;
    end
  end

  // Handshake/bus flags registered from the next state so they switch on the
  // same edge as the FSM (cyc drops on the edge that leaves BUS).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q       <= 1'b1;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      rdy_q       <= (state_d == S_IDLE);
      cyc_q       <= (state_d == S_BUS);
      rsp_valid_q <= (state_d == S_RESP);
    end
  end

  // Command capture; held stable for the whole transfer including retries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      adr_q <= 32'h0000_0000;
      sel_q <= 4'h0;
      dat_q <= 32'h0000_0000;
    end else if (cmd_take_s) begin
      we_q  <= i_cmd_we;
      adr_q <= i_cmd_adr;
      sel_q <= i_cmd_sel;
      dat_q <= i_cmd_dat;
    end else begin
      we_q  <= we_q;
      adr_q <= adr_q;
      sel_q <= sel_q;
      dat_q <= dat_q;
    end
  end

  assign o_cmd_ready  = rdy_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_dat    = rsp_dat_q;
  assign o_rsp_status = status_q;
  assign o_wb_adr     = adr_q;
  assign o_wb_sel     = sel_q;
  assign o_wb_we      = we_q;
  assign o_wb_dat     = dat_q;
  assign o_wb_cyc     = cyc_q;
  assign o_wb_stb     = cyc_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator (TIMEOUT_CYC=16, RETRY_MAX=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_wb_cmd_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cmd_valid, i_cmd_we, i_rsp_ready;
  logic [31:0] i_cmd_adr, i_cmd_dat, i_wb_dat;
  logic [3:0]  i_cmd_sel;
  logic        o_cmd_ready, o_rsp_valid, o_wb_we, o_wb_cyc, o_wb_stb;
  logic [31:0] o_rsp_dat, o_wb_adr, o_wb_dat;
  logic [1:0]  o_rsp_status;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack, i_wb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_cmd_initiator #(.TIMEOUT_CYC(16), .RETRY_MAX(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
    .i_cmd_adr(i_cmd_adr), .i_cmd_sel(i_cmd_sel), .i_cmd_dat(i_cmd_dat),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_dat(o_rsp_dat),
    .o_rsp_status(o_rsp_status),
    .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we), .o_wb_dat(o_wb_dat),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err)
  );

  // Present one command for one edge; returns at the falling edge of bus cycle 1.
  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat);
    i_cmd_valid = 1'b1; i_cmd_we = we; i_cmd_adr = adr; i_cmd_sel = sel; i_cmd_dat = dat;
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  // Consume the pending response with a one-cycle ready pulse.
  task automatic take_rsp();
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_we = 1'b0; i_cmd_adr = 32'h0; i_cmd_sel = 4'h0; i_cmd_dat = 32'h0;
    i_rsp_ready = 1'b0; i_wb_dat = 32'h0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_wb_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b exp 0", o_wb_cyc); end
    checks++; if (o_wb_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %b exp 0", o_wb_stb); end
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", o_rsp_valid); end
    checks++; if (o_wb_adr !== 32'h0) begin errors++; $display("FAIL reset_adr got %h exp 0", o_wb_adr); end
    checks++; if (o_rsp_status !== 2'b00) begin errors++; $display("FAIL reset_status got %b exp 00", o_rsp_status); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_cmd_ready); end
  endtask

  task automatic test_read_basic();
    send_cmd(1'b0, 32'h0000_0100, 4'hF, 32'h0);
    checks++; if (o_wb_cyc !== 1'b1 || o_wb_stb !== 1'b1) begin errors++; $display("FAIL rd_cyc got %b/%b exp 1/1", o_wb_cyc, o_wb_stb); end
    checks++; if (o_wb_adr !== 32'h0000_0100 || o_wb_we !== 1'b0) begin errors++; $display("FAIL rd_adr got %h we %b exp 100 we 0", o_wb_adr, o_wb_we); end
    checks++; if (o_cmd_ready !== 1'b0) begin errors++; $display("FAIL rd_busy_ready got %b exp 0", o_cmd_ready); end
    i_wb_ack = 1'b1; i_wb_dat = 32'hDEAD_BEEF;
    @(negedge clk);
    i_wb_ack = 1'b0;
    checks++; if (o_rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid got %b exp 1", o_rsp_valid); end
    checks++; if (o_rsp_dat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rsp_dat got %h exp deadbeef", o_rsp_dat); end
    checks++; if (o_rsp_status !== 2'b00) begin errors++; $display("FAIL rd_status got %b exp 00", o_rsp_status); end
    checks++; if (o_wb_cyc !== 1'b0 || o_cmd_ready !== 1'b0) begin errors++; $display("FAIL rd_rsp_cyc_ready got %b/%b exp 0/0", o_wb_cyc, o_cmd_ready); end
    take_rsp();
    checks++; if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_back_idle got %b/%b exp 0/1", o_rsp_valid, o_cmd_ready); end
  endtask

  task automatic test_write_waits();
    send_cmd(1'b1, 32'h0000_0200, 4'h3, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_wb_cyc !== 1'b1 || o_wb_we !== 1'b1 || o_wb_dat !== 32'h1234_5678 || o_wb_sel !== 4'h3 || o_wb_adr !== 32'h0000_0200) begin
        errors++; $display("FAIL wr_hold[%0d] got cyc %b we %b dat %h sel %h adr %h exp 1 1 12345678 3 200", i, o_wb_cyc, o_wb_we, o_wb_dat, o_wb_sel, o_wb_adr);
      end
      if (i == 3) begin i_wb_ack = 1'b1; i_wb_dat = 32'hFFFF_FFFF; end
      @(negedge clk);
    end
    i_wb_ack = 1'b0;
    checks++; if (o_rsp_valid !== 1'b1 || o_wb_cyc !== 1'b0) begin errors++; $display("FAIL wr_rsp_valid got %b cyc %b exp 1 0", o_rsp_valid, o_wb_cyc); end
    checks++; if (o_rsp_dat !== 32'h0 || o_rsp_status !== 2'b00) begin errors++; $display("FAIL wr_rsp got %h/%b exp 0/00", o_rsp_dat, o_rsp_status); end
    take_rsp();
  endtask

  task automatic test_byte_mask();
    send_cmd(1'b0, 32'h0000_0300, 4'b0101, 32'h0);
    checks++; if (o_wb_sel !== 4'b0101) begin errors++; $display("FAIL mask_sel got %b exp 0101", o_wb_sel); end
    i_wb_ack = 1'b1; i_wb_dat = 32'hAABB_CCDD;
    @(negedge clk);
    i_wb_ack = 1'b0;
    checks++; if (o_rsp_dat !== 32'h00BB_00DD || o_rsp_status !== 2'b00) begin errors++; $display("FAIL mask_dat got %h/%b exp 00bb00dd/00", o_rsp_dat, o_rsp_status); end
    take_rsp();
  endtask

  task automatic test_retry();
    // two errors, then ack
    send_cmd(1'b0, 32'h0000_0400, 4'hF, 32'h0);
    for (int a = 0; a < 2; a++) begin
      checks++; if (o_wb_cyc !== 1'b1) begin errors++; $display("FAIL retry_bus[%0d] got %b exp 1", a, o_wb_cyc); end
      i_wb_err = 1'b1;
      @(negedge clk);
      i_wb_err = 1'b0;
      checks++; if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0 || o_rsp_valid !== 1'b0) begin errors++; $display("FAIL retry_gap[%0d] got cyc %b stb %b vld %b exp 0 0 0", a, o_wb_cyc, o_wb_stb, o_rsp_valid); end
      @(negedge clk);
    end
    checks++; if (o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h0000_0400) begin errors++; $display("FAIL retry_third got cyc %b adr %h exp 1 400", o_wb_cyc, o_wb_adr); end
    i_wb_ack = 1'b1; i_wb_dat = 32'h1122_3344;
    @(negedge clk);
    i_wb_ack = 1'b0;
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_dat !== 32'h1122_3344 || o_rsp_status !== 2'b00) begin errors++; $display("FAIL retry_ok got %b %h %b exp 1 11223344 00", o_rsp_valid, o_rsp_dat, o_rsp_status); end
    take_rsp();
    // error on all three attempts
    send_cmd(1'b0, 32'h0000_0404, 4'hF, 32'h0);
    for (int a = 0; a < 3; a++) begin
      i_wb_err = 1'b1; i_wb_dat = 32'h9999_9999;
      @(negedge clk);
      i_wb_err = 1'b0;
      if (a < 2) @(negedge clk);
    end
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_status !== 2'b01 || o_rsp_dat !== 32'h0) begin errors++; $display("FAIL retry_err got %b %b %h exp 1 01 0", o_rsp_valid, o_rsp_status, o_rsp_dat); end
    take_rsp();
  endtask

  task automatic test_timeout();
    send_cmd(1'b0, 32'h0000_0500, 4'hF, 32'h0);
    for (int i = 0; i < 16; i++) begin
      checks++; if (o_wb_cyc !== 1'b1) begin errors++; $display("FAIL to_bus[%0d] got %b exp 1", i, o_wb_cyc); end
      @(negedge clk);
    end
    checks++; if (o_wb_cyc !== 1'b0 || o_rsp_valid !== 1'b1) begin errors++; $display("FAIL to_end got cyc %b vld %b exp 0 1", o_wb_cyc, o_rsp_valid); end
    checks++; if (o_rsp_status !== 2'b10 || o_rsp_dat !== 32'h0) begin errors++; $display("FAIL to_rsp got %b %h exp 10 0", o_rsp_status, o_rsp_dat); end
    take_rsp();
    // ack and err together count as err (first attempt -> retry gap)
    send_cmd(1'b0, 32'h0000_0504, 4'hF, 32'h0);
    i_wb_ack = 1'b1; i_wb_err = 1'b1; i_wb_dat = 32'h7777_7777;
    @(negedge clk);
    i_wb_ack = 1'b0; i_wb_err = 1'b0;
    checks++; if (o_wb_cyc !== 1'b0 || o_rsp_valid !== 1'b0) begin errors++; $display("FAIL ackerr_gap got cyc %b vld %b exp 0 0", o_wb_cyc, o_rsp_valid); end
    @(negedge clk);
    i_wb_ack = 1'b1; i_wb_dat = 32'h0000_0055;
    @(negedge clk);
    i_wb_ack = 1'b0;
    checks++; if (o_rsp_dat !== 32'h0000_0055 || o_rsp_status !== 2'b00) begin errors++; $display("FAIL ackerr_final got %h %b exp 55 00", o_rsp_dat, o_rsp_status); end
    take_rsp();
  endtask

  task automatic test_reset_mid_bus();
    send_cmd(1'b0, 32'h0000_0600, 4'hF, 32'h0);
    checks++; if (o_wb_cyc !== 1'b1) begin errors++; $display("FAIL rstbus_pre got %b exp 1", o_wb_cyc); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0) begin errors++; $display("FAIL rstbus_cyc got %b/%b exp 0/0", o_wb_cyc, o_wb_stb); end
    @(negedge clk);
    rst_n = 1'b1;
    i_wb_ack = 1'b1; i_wb_dat = 32'h1357_9BDF;
    repeat (2) @(negedge clk);
    i_wb_ack = 1'b0;
    checks++; if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_wb_cyc !== 1'b0) begin errors++; $display("FAIL rstbus_after got vld %b rdy %b cyc %b exp 0 1 0", o_rsp_valid, o_cmd_ready, o_wb_cyc); end
  endtask

  task automatic test_rsp_hold();
    send_cmd(1'b0, 32'h0000_0700, 4'hF, 32'h0);
    i_wb_ack = 1'b1; i_wb_dat = 32'hCAFE_F00D;
    @(negedge clk);
    i_wb_ack = 1'b0; i_wb_dat = 32'h0;
    i_cmd_valid = 1'b1; i_cmd_adr = 32'h0000_0800;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_rsp_valid !== 1'b1 || o_rsp_dat !== 32'hCAFE_F00D || o_rsp_status !== 2'b00 || o_cmd_ready !== 1'b0 || o_wb_cyc !== 1'b0) begin
        errors++; $display("FAIL hold[%0d] got vld %b dat %h st %b rdy %b cyc %b exp 1 cafef00d 00 0 0", i, o_rsp_valid, o_rsp_dat, o_rsp_status, o_cmd_ready, o_wb_cyc);
      end
      @(negedge clk);
    end
    i_cmd_valid = 1'b0;
    take_rsp();
    checks++; if (o_cmd_ready !== 1'b1 || o_wb_adr !== 32'h0000_0700) begin errors++; $display("FAIL hold_release got rdy %b adr %h exp 1 700", o_cmd_ready, o_wb_adr); end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_waits();
    test_byte_mask();
    test_retry();
    test_timeout();
    test_reset_mid_bus();
    test_rsp_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
